window_scan_sequencer: RTL
==========================

// Module: window_scan_sequencer
// PURPOSE
//  Frame-level sequencer for the KxK window buffer. Counts incoming pixel columns
//  (K pixels each) from the line buffers and drives the window shift enable. Flags
//  each cycle in which the window registers hold a complete in-image window, with
//  its coordinates. Signals end of frame. Sits between the line buffers and the
//  window buffer plus its filter.
// PARAMETERS
//  COLS   640  image width in pixels
//  ROWS   480  image height in pixels
//  K      11   window size; require K <= COLS and K <= ROWS
// PORTS
//  clk              in   1   clock; all logic on rising edge
//  rst              in   1   synchronous reset, active-high
//  start_i          in   1   start a frame; honoured only in IDLE
//  valid_i          in   1   one K-pixel column presented this cycle
//  shift_en_o       out  1   window buffer shift enable (combinational)
//  window_valid_o   out  1   window registers hold a full in-image window
//  win_col_o        out  CW  window left column, CW=$clog2(COLS)
//  win_row_o        out  RW  window top row, RW=$clog2(ROWS)
//  busy_o           out  1   state != IDLE
//  done_o           out  1   one-cycle end-of-frame pulse
//  progress_done_o  out  1   sticky frame-complete flag
//  err_o            out  1   sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; counters=0; every output 0.
//  - FSM states: IDLE, RUN, DRAIN, DONE.
//    - IDLE->RUN on start_i. This clears the counters and progress_done_o.
//    - RUN->DRAIN when the last column is accepted (col=COLS-1, row=ROWS-K).
//    - DRAIN->DONE unconditionally.
//    - DONE->IDLE unconditionally.
//  - shift_en_o = valid_i && state==RUN. No other state shifts; valid_i there is dropped.
//  - Column counter col: 0..COLS-1. Advances on each accepted column.
//  - Row counter row: 0..ROWS-K. Advances when col wraps COLS-1->0.
//  - If valid_i is low in RUN, the counters and all outputs hold.
//  - window_valid_o is registered: high in cycle T+1 iff a column with col>=K-1 was accepted at T.
//  - win_col_o=col-(K-1) and win_row_o=row, sampled at T (registered). Hold value otherwise.
//  - Window count per frame = (COLS-K+1)*(ROWS-K+1). No window spans a row band boundary.
//  - Last column accepted at T:
//    - final window_valid_o at T+1 (state DRAIN);
//    - done_o=1 at T+2 only (state DONE, Moore);
//    - progress_done_o rises at T+2 and stays high until the next start_i is accepted.
//  - start_i outside IDLE is ignored; a second start_i does not restart a frame.
//  - start_i and valid_i in the same IDLE cycle: start only, no shift.
//    The first column is accepted in RUN.
//  - rst mid-frame: returns to IDLE next cycle; all outputs 0; no done_o pulse.
//  - Counter arithmetic is unsigned at widths CW/RW. No saturation; wrap is explicit by compare.
// CONFIGURATION
//  Macro WIN_SEQ_OVERRUN_CHK_EN:
//   - Defined: err_o is set when valid_i=1 in IDLE, DRAIN or DONE.
//     err_o stays set until rst or an accepted start_i.
//   - Undefined: err_o tied 0 and no check logic exists.
//     Dropping stray valid_i is unchanged.
// STRUCTURE
//  - Package win_seq_pkg holds:
//    - state enum (IDLE/RUN/DRAIN/DONE, 2-bit encoding);
//    - default K constant;
//    - width helper for CW/RW.
//  - Sub-module win_seq_wrap_counter, instantiated for col and row.
//    - Parameter MAX.
//    - Ports: clear, inc, value, at_max.
//    - Wraps to 0 on inc at MAX.
// TESTING (COLS=16, ROWS=13, K=11: 48 columns, 18 windows/frame)
//  1. Reset held 3 cycles, random inputs -> every output 0, busy_o=0.
//  2. start_i, then 48 back-to-back valid_i:
//     -> first window_valid_o one cycle after the 11th column, with win_col_o=0, win_row_o=0;
//     -> 18 window_valid_o pulses; last one has win_col_o=5, win_row_o=2;
//     -> done_o pulse 2 cycles after the last column; progress_done_o stays 1.
//  3. Same frame with random 0-3 cycle valid_i gaps -> same 18 windows and coordinates;
//     outputs hold during gaps.
//  4. rst asserted after column 20 -> all outputs 0 next cycle, no done_o;
//     then a new start_i and 48 columns -> full 18-window frame.
//  5. start_i pulsed at column 10 of RUN -> ignored; counts continue; single done_o.
//  6. valid_i in IDLE:
//     -> macro on: err_o=1, held until start_i;
//     -> macro off: err_o=0;
//     -> both: shift_en_o=0.

Source files
------------

// File: rtl/win_seq_pkg.sv
// Shared types and helpers for the window scan sequencer: FSM state encoding,
// default window size and the counter width helper.
package win_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEFAULT_K = 11;

    // Bits needed to index 0..n-1, never less than one bit.
    function automatic int clog2_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/win_seq_wrap_counter.sv
// Up-counter that wraps to 0 when incremented at MAX; used for the column and
// row-band position of the window scan.
module win_seq_wrap_counter #(
    parameter int MAX = 15,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         at_max
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    assign at_max = (value_q == W'(MAX));
    assign value  = value_q;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (inc) begin
            value_d = at_max ? '0 : value_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/window_scan_sequencer.sv
// Frame sequencer for the KxK window buffer: accepts pixel columns, drives the
// shift enable and flags complete windows. Optional overrun check: WIN_SEQ_OVERRUN_CHK_EN.
module window_scan_sequencer
    import win_seq_pkg::*;
#(
    parameter int COLS = 640,
    parameter int ROWS = 480,
    parameter int K    = DEFAULT_K,
    localparam int CW  = clog2_w(COLS),
    localparam int RW  = clog2_w(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          valid_i,
    output logic          shift_en_o,
    output logic          window_valid_o,
    output logic [CW-1:0] win_col_o,
    output logic [RW-1:0] win_row_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          progress_done_o,
    output logic          err_o
);

    localparam logic [CW-1:0] K_LAST = CW'(K - 1);

    state_e        state_q, state_d;
    logic          window_valid_q, window_valid_d;
    logic [CW-1:0] win_col_q, win_col_d;
    logic [RW-1:0] win_row_q, win_row_d;
    logic          progress_q, progress_d;

    logic          start_acc;
    logic          accept;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_at_max;
    logic          row_at_max;

    assign start_acc  = start_i && (state_q == IDLE);
    assign accept     = valid_i && (state_q == RUN);
    assign shift_en_o = accept;

    win_seq_wrap_counter #(.MAX(COLS - 1), .W(CW)) u_col_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_acc),
        .inc    (accept),
        .value  (col),
        .at_max (col_at_max)
    );

    win_seq_wrap_counter #(.MAX(ROWS - K), .W(RW)) u_row_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_acc),
        .inc    (accept && col_at_max),
        .value  (row),
        .at_max (row_at_max)
    );

    always_comb begin
        state_d        = state_q;
        window_valid_d = 1'b0;
        win_col_d      = win_col_q;
        win_row_d      = win_row_q;
        progress_d     = progress_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = RUN;
                    progress_d = 1'b0;
                end
            end
            RUN: begin
                if (accept && col_at_max && row_at_max) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A window is complete once K columns of the current band have shifted in.
        if (accept && (col >= K_LAST)) begin
            window_valid_d = 1'b1;
            win_col_d      = col - K_LAST;
            win_row_d      = row;
        end
        if (state_q == DRAIN) begin
            progress_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            window_valid_q <= 1'b0;
            win_col_q      <= '0;
            win_row_q      <= '0;
            progress_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            window_valid_q <= window_valid_d;
            win_col_q      <= win_col_d;
            win_row_q      <= win_row_d;
            progress_q     <= progress_d;
        end
    end

`ifdef WIN_SEQ_OVERRUN_CHK_EN
    logic err_q, err_d;

    // An accepted start clears the flag even if a stray column arrives with it.
    always_comb begin
        err_d = err_q;
        if (start_acc) begin
            err_d = 1'b0;
        end else if (valid_i && (state_q != RUN)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign window_valid_o  = window_valid_q;
    assign win_col_o       = win_col_q;
    assign win_row_o       = win_row_q;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign progress_done_o = progress_q;

endmodule
